adder_array_pipe: RTL

Pipelined, parametrised successor of the four-channel adder array. Takes NCH channels of WIDTH-bit operand pairs, adds or subtracts them in a two-stage registered datapath with valid/ready flow control, and reports per-channel signed overflow. Sticky overflow status is held until software clears it. Sits between the lab operand source and the result sink/AXI wrapper.

---
 rtl/adder_array_pipe.sv | 109 ++++++++++
 1 files changed

// File: rtl/adder_array_pipe.sv
// Two-stage pipelined NCH-channel add/subtract array with per-channel signed
// overflow flags and a sticky overflow register cleared by ovf_clr.
module adder_array_pipe #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int CW    = $clog2(NCH) + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CW-1:0]        cmd,
  input  logic                 op,
  input  logic [NCH*WIDTH-1:0] ain,
  input  logic [NCH*WIDTH-1:0] bin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] dout,
  output logic [NCH-1:0]       overflow,
  output logic [NCH-1:0]       ovf_sticky,
  input  logic                 ovf_clr
);

  // Handshake: a beat transfers on a rising edge where valid && ready are both
  // high; a producer holding valid keeps its payload stable until it transfers.
  logic                 v1, v2;
  logic                 op1;
  logic [CW-1:0]        cmd1;
  logic [NCH*WIDTH-1:0] a1, b1;
  logic                 s1_load, s2_load, in_fire;
  logic [NCH*WIDTH-1:0] r_next;
  logic [NCH-1:0]       ovf_next;

  assign s2_load   = !v2 || out_ready;
  assign s1_load   = !v1 || s2_load;
  assign in_ready  = !v1 || !v2 || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = v2;

  always_comb begin : calc_p
    logic [WIDTH-1:0] ca, cb, cbx, cr;
    logic             en;
    r_next   = '0;
    ovf_next = '0;
    ca       = '0;
    cb       = '0;
    cbx      = '0;
    cr       = '0;
    en       = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      ca  = a1[i*WIDTH +: WIDTH];
      cb  = b1[i*WIDTH +: WIDTH];
      // Subtraction as a + ~b + 1; carry-out is intentionally dropped.
      cbx = op1 ? ~cb : cb;
      cr  = ca + cbx + WIDTH'(op1);
      en  = (cmd1 == CW'(i)) || (cmd1 == CW'(NCH));
      if (en) begin
        r_next[i*WIDTH +: WIDTH] = cr;
        if (op1)
          ovf_next[i] = (ca[WIDTH-1] != cb[WIDTH-1]) && (cr[WIDTH-1] != ca[WIDTH-1]);
        else
          ovf_next[i] = (ca[WIDTH-1] == cb[WIDTH-1]) && (cr[WIDTH-1] != ca[WIDTH-1]);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1   <= 1'b0;
      op1  <= 1'b0;
      cmd1 <= '0;
      a1   <= '0;
      b1   <= '0;
    end else if (s1_load) begin
      v1 <= in_fire;
      if (in_fire) begin
        op1  <= op;
        cmd1 <= cmd;
        a1   <= ain;
        b1   <= bin;
      end
    end
  end

  // S2 only reloads when its current beat is gone, so a stalled result holds.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2       <= 1'b0;
      dout     <= '0;
      overflow <= '0;
    end else if (s2_load) begin
      v2 <= v1;
      if (v1) begin
        dout     <= r_next;
        overflow <= ovf_next;
      end
    end
  end

  // A new overflow event landing on the clear cycle survives the clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_sticky <= '0;
    end else begin
      ovf_sticky <= (ovf_clr ? '0 : ovf_sticky) | ((s2_load && v1) ? ovf_next : '0);
    end
  end

endmodule
